// File: rtl/sc_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one iword per instruction over req/ack,
// and computes the next PC. Optional macro ALIGN_CHECK_EN adds a misaligned-next-PC trap.
module sc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] iword,
    output logic        iword_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        pc_sel,
    input  logic        is_jal,
    input  logic [15:0] br_imm,
    input  logic [31:0] jal_target,
    output logic        fetch_fault
);

`ifdef ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] iword_q;
    logic [31:0] iword_d;
    logic [31:0] pc_plus4_s;
    logic [31:0] br_off_s;
    logic [31:0] next_pc_s;
    logic        commit_s;
    logic        imem_req_s;
    logic        iword_valid_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign br_off_s   = {{14{br_imm[15]}}, br_imm, 2'b00};
    assign commit_s   = (state_q == ST_EXEC) && commit;

    // Next-PC selection: JAL beats a taken branch, which beats sequential flow.
    always_comb begin
        if (is_jal) begin
            next_pc_s = jal_target;
        end else if (pc_sel) begin
            next_pc_s = pc_plus4_s + br_off_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (commit) begin
`ifdef ALIGN_CHECK_EN
                    if (next_pc_s[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_FETCH;
                    end
`else
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
`ifdef ALIGN_CHECK_EN
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`endif
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        imem_req_s    = 1'b0;
        iword_valid_s = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_s = 1'b1;
            end
            ST_EXEC: begin
                iword_valid_s = 1'b1;
            end
            default: begin
                imem_req_s    = 1'b0;
                iword_valid_s = 1'b0;
            end
        endcase
    end

    // PC and iword next values; iword is captured only on an ack while fetching.
    always_comb begin
        pc_d    = pc_q;
        iword_d = iword_q;
        if ((state_q == ST_FETCH) && imem_ack) begin
            iword_d = imem_rdata;
        end else begin
            iword_d = iword_q;
        end
        if (commit_s) begin
`ifdef ALIGN_CHECK_EN
            pc_d = next_pc_s;
`else
            pc_d = next_pc_s & ~32'd3;
`endif
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and instruction registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            iword_q <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            iword_q <= iword_d;
        end
    end

`ifdef ALIGN_CHECK_EN
    logic fetch_fault_q;
    logic fetch_fault_d;

    // Fault flag is sticky until reset.
    always_comb begin
        fetch_fault_d = fetch_fault_q;
        if (commit_s && (next_pc_s[1:0] != 2'b00)) begin
            fetch_fault_d = 1'b1;
        end else begin
            fetch_fault_d = fetch_fault_q;
        end
    end

    // Fault flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_fault_q <= 1'b0;
        end else begin
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign fetch_fault = fetch_fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req    = imem_req_s;
    assign imem_addr   = pc_q;
    assign iword       = iword_q;
    assign iword_valid = iword_valid_s;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Scoreboard bench for sc_fetch_unit: expected fetch addresses and iwords are queued
// by the stimulus and popped by a monitor when the DUT raises imem_req / iword_valid.
module tb_sc_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] iword;
    logic        iword_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic        pc_sel;
    logic        is_jal;
    logic [15:0] br_imm;
    logic [31:0] jal_target;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_iw_q[$];
    logic        prev_req   = 1'b0;
    logic        prev_valid = 1'b0;

    sc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .iword      (iword),
        .iword_valid(iword_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .commit     (commit),
        .pc_sel     (pc_sel),
        .is_jal     (is_jal),
        .br_imm     (br_imm),
        .jal_target (jal_target),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare each new request address and each newly valid iword against the queues.
    always @(negedge clk) begin
        if (imem_req && !prev_req) begin
            if (exp_addr_q.size() == 0) begin
                check32("unexpected_req", imem_addr, 32'hFFFF_FFFF);
            end else begin
                check32("fetch_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
        if (iword_valid && !prev_valid) begin
            if (exp_iw_q.size() == 0) begin
                check32("unexpected_iword", iword, 32'hFFFF_FFFF);
            end else begin
                check32("iword", iword, exp_iw_q.pop_front());
            end
        end
        prev_req   = imem_req;
        prev_valid = iword_valid;
    end

    // Memory side: wait for a request, insert ws wait states, then acknowledge with data.
    task automatic do_fetch(input int ws, input logic [31:0] data);
        int          n;
        logic [31:0] a;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            check32("req_timeout", {31'd0, imem_req}, 32'd1);
            return;
        end
        a = imem_addr;
        for (int i = 0; i < ws; i++) begin
            @(negedge clk);
            check32("req_held", {31'd0, imem_req}, 32'd1);
            check32("addr_held", imem_addr, a);
        end
        imem_rdata = data;
        imem_ack   = 1'b1;
        exp_iw_q.push_back(data);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check32("req_drop", {31'd0, imem_req}, 32'd0);
    endtask

    // Datapath side: check EXEC state, hold one cycle with ignored inputs, then commit.
    task automatic do_exec(input logic sel, input logic jal, input logic [15:0] imm,
                           input logic [31:0] tgt, input logic [31:0] exp_pc,
                           input logic [31:0] exp_p4, input logic [31:0] word,
                           input logic [31:0] exp_next, input logic push_next);
        int n;
        n = 0;
        while (!iword_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!iword_valid) begin
            check32("valid_timeout", {31'd0, iword_valid}, 32'd1);
            return;
        end
        check32("exec_pc", pc, exp_pc);
        check32("exec_pc_plus4", pc_plus4, exp_p4);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        pc_sel     = 1'b1;
        is_jal     = 1'b1;
        jal_target = 32'h0000_0BBB;
        @(negedge clk);
        imem_ack = 1'b0;
        check32("iword_hold", iword, word);
        check32("valid_hold", {31'd0, iword_valid}, 32'd1);
        check32("pc_hold", pc, exp_pc);
        pc_sel     = sel;
        is_jal     = jal;
        br_imm     = imm;
        jal_target = tgt;
        commit     = 1'b1;
        if (push_next) begin
            exp_addr_q.push_back(exp_next);
        end
        @(negedge clk);
        commit     = 1'b0;
        pc_sel     = 1'b0;
        is_jal     = 1'b0;
        br_imm     = 16'h0000;
        jal_target = 32'h0000_0000;
    endtask

    initial begin
        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0000_0000;
        commit     = 1'b0;
        pc_sel     = 1'b0;
        is_jal     = 1'b0;
        br_imm     = 16'h0000;
        jal_target = 32'h0000_0000;
        repeat (3) @(negedge clk);
        check32("rst_pc", pc, 32'h0000_0000);
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_valid", {31'd0, iword_valid}, 32'd0);
        check32("rst_iword", iword, 32'h0000_0000);
        check32("rst_fault", {31'd0, fetch_fault}, 32'd0);

        exp_addr_q.push_back(32'h0000_0000);
        reset_n = 1'b1;
        #1;
        check32("req_first_cycle", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check32("req_second_cycle", {31'd0, imem_req}, 32'd1);

        do_fetch(0, 32'h1234_5678);
        do_exec(1'b0, 1'b0, 16'h0000, 32'h0, 32'h0000_0000, 32'h0000_0004,
                32'h1234_5678, 32'h0000_0004, 1'b1);
        do_fetch(3, 32'hA5A5_0001);
        do_exec(1'b1, 1'b0, 16'h0002, 32'h0, 32'h0000_0004, 32'h0000_0008,
                32'hA5A5_0001, 32'h0000_0010, 1'b1);
        do_fetch(1, 32'h0000_0013);
        do_exec(1'b1, 1'b0, 16'hFFFE, 32'h0, 32'h0000_0010, 32'h0000_0014,
                32'h0000_0013, 32'h0000_000C, 1'b1);
        do_fetch(2, 32'h0000_006F);
        do_exec(1'b0, 1'b1, 16'h0000, 32'h0000_0020, 32'h0000_000C, 32'h0000_0010,
                32'h0000_006F, 32'h0000_0020, 1'b1);
        do_fetch(0, 32'h0100_006F);
        do_exec(1'b1, 1'b1, 16'h0040, 32'h0000_0100, 32'h0000_0020, 32'h0000_0024,
                32'h0100_006F, 32'h0000_0100, 1'b1);
        do_fetch(0, 32'hCAFE_0000);
        do_exec(1'b0, 1'b1, 16'h0000, 32'hFFFF_FFFC, 32'h0000_0100, 32'h0000_0104,
                32'hCAFE_0000, 32'hFFFF_FFFC, 1'b1);
        do_fetch(1, 32'h0BAD_F00D);
        do_exec(1'b0, 1'b0, 16'h0000, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000,
                32'h0BAD_F00D, 32'h0000_0000, 1'b1);
        do_fetch(0, 32'h1111_2222);
        do_exec(1'b0, 1'b0, 16'h0000, 32'h0, 32'h0000_0000, 32'h0000_0004,
                32'h1111_2222, 32'h0000_0004, 1'b1);

        // Abort a fetch that is waiting on memory.
        @(negedge clk);
        check32("wait_addr", imem_addr, 32'h0000_0004);
        reset_n = 1'b0;
        #1;
        check32("abort_pc", pc, 32'h0000_0000);
        check32("abort_req", {31'd0, imem_req}, 32'd0);
        check32("abort_valid", {31'd0, iword_valid}, 32'd0);
        check32("abort_iword", iword, 32'h0000_0000);
        check32("abort_fault", {31'd0, fetch_fault}, 32'd0);
        @(negedge clk);
        exp_addr_q.push_back(32'h0000_0000);
        reset_n = 1'b1;
        do_fetch(0, 32'h3333_4444);
`ifdef ALIGN_CHECK_EN
        do_exec(1'b0, 1'b1, 16'h0000, 32'h0000_0102, 32'h0000_0000, 32'h0000_0004,
                32'h3333_4444, 32'h0000_0102, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check32("fault_flag", {31'd0, fetch_fault}, 32'd1);
            check32("fault_req", {31'd0, imem_req}, 32'd0);
            check32("fault_valid", {31'd0, iword_valid}, 32'd0);
            check32("fault_pc", pc, 32'h0000_0102);
            @(negedge clk);
        end
`else
        do_exec(1'b0, 1'b1, 16'h0000, 32'h0000_0102, 32'h0000_0000, 32'h0000_0004,
                32'h3333_4444, 32'h0000_0100, 1'b1);
        check32("aligned_pc", pc, 32'h0000_0100);
        check32("no_fault", {31'd0, fetch_fault}, 32'd0);
        do_fetch(0, 32'h5555_6666);
        @(negedge clk);
`endif
        check32("addr_queue_empty", exp_addr_q.size(), 32'd0);
        check32("iword_queue_empty", exp_iw_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends with a summary.
    initial begin
        #20000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
